compute_plain_broadcast_split: RTL and testbench



---
 rtl/compute_plain_broadcast_split.sv | 223 ++++++++++++++++++++++
 tb/tb_compute_plain_broadcast_split.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_plain_broadcast_split.sv
// Plain broadcast values per split: alpha = eps*Q(r) + a, beta = S(r) + b over GF(2^32), lane by lane.
// Optional abort input is compiled in when PLAIN_BCAST_ABORT_EN is defined.
module compute_plain_broadcast_split #(
    parameter string PARAMETER_SET = "L1",
    parameter int    M             = (PARAMETER_SET == "L5") ? 480 : ((PARAMETER_SET == "L3") ? 352 : 230),
    parameter int    T             = (PARAMETER_SET == "L5") ? 4 : 3,
    parameter int    D_SPLIT       = (PARAMETER_SET == "L1") ? 1 : 2,
    localparam int   AW            = $clog2(M),
    localparam int   SW            = $clog2(D_SPLIT) + 1,
    localparam int   TW            = 32 * T
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
`ifdef PLAIN_BCAST_ABORT_EN
    input  logic          i_abort,
`endif
    output logic [SW-1:0] o_split_idx,
    input  logic [TW-1:0] i_r,
    input  logic [TW-1:0] i_eps,
    input  logic [TW-1:0] i_a,
    input  logic [TW-1:0] i_b,
    input  logic [7:0]    i_q,
    input  logic [7:0]    i_s,
    output logic [AW-1:0] o_q_addr,
    output logic [AW-1:0] o_s_addr,
    output logic          o_q_rd,
    output logic          o_s_rd,
    output logic          o_start_evaluate,
    output logic [7:0]    o_q_s,
    input  logic [AW-1:0] i_q_s_addr,
    input  logic          i_q_s_rd,
    output logic [TW-1:0] o_r_eps,
    input  logic [TW-1:0] i_evaluate_out,
    input  logic          i_done_evaluate,
    output logic          o_start_mul32,
    output logic [31:0]   o_x_mul32,
    output logic [31:0]   o_y_mul32,
    input  logic [31:0]   i_o_mul32,
    input  logic          i_done_mul32,
    output logic          o_start_add32,
    output logic [TW-1:0] o_in_1_add32,
    output logic [TW-1:0] o_in_2_add32,
    input  logic [TW-1:0] i_add_out_add32,
    input  logic          i_done_add32,
    output logic [TW-1:0] o_alpha,
    output logic [TW-1:0] o_beta,
    output logic          o_split_valid,
    output logic          o_busy,
    output logic          o_done
);

    // state        | meaning
    // IDLE         | waiting for i_start
    // R_EVAL_*     | evaluate Q at r (start strobe / wait for done)
    // MUL_*        | eps * Q(r), one lane at a time
    // ADD_A_*      | alpha = product + a
    // S_EVAL_*     | evaluate S at r
    // ADD_B_*      | beta = S(r) + b
    // EMIT         | o_split_valid; next split or finish
    // DONE         | o_done pulse
    typedef enum logic [3:0] {
        IDLE,
        R_EVAL_START,
        R_EVAL_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        ADD_A_START,
        ADD_A_WAIT,
        S_EVAL_START,
        S_EVAL_WAIT,
        ADD_B_START,
        ADD_B_WAIT,
        EMIT,
        DONE
    } state_t;

    localparam int            LW         = (T > 1) ? $clog2(T) : 1;
    localparam logic [LW-1:0] LAST_LANE  = LW'(T - 1);
    localparam logic [SW-1:0] LAST_SPLIT = SW'(D_SPLIT - 1);

    state_t        state;
    logic [LW-1:0] lane;
    logic [TW-1:0] work;
    logic [TW-1:0] eps;
    logic [TW-1:0] work_upd;
    logic          abort_req;

`ifdef PLAIN_BCAST_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    // Lane 0 sits in the most significant 32 bits.
    function automatic logic [31:0] lane_of(input logic [TW-1:0] v, input int j);
        return v[32*(T-1-j) +: 32];
    endfunction

    always_comb begin
        work_upd = work;
        work_upd[32*(T-1-int'(lane)) +: 32] = i_o_mul32;
    end

    assign o_q_addr = i_q_s_addr;
    assign o_s_addr = i_q_s_addr;
    assign o_q_rd   = i_q_s_rd;
    assign o_s_rd   = i_q_s_rd;
    assign o_r_eps  = i_r;
    assign o_q_s    = (state == R_EVAL_START || state == R_EVAL_WAIT) ? i_q : i_s;

    // Start strobes are registered on entry to the *_START/ISSUE states so they are high exactly there.
    always_ff @(posedge i_clk) begin
        o_start_evaluate <= 1'b0;
        o_start_mul32    <= 1'b0;
        o_start_add32    <= 1'b0;
        o_split_valid    <= 1'b0;
        o_done           <= 1'b0;
        if (i_rst) begin
            state        <= IDLE;
            lane         <= '0;
            work         <= '0;
            eps          <= '0;
            o_split_idx  <= '0;
            o_x_mul32    <= '0;
            o_y_mul32    <= '0;
            o_in_1_add32 <= '0;
            o_in_2_add32 <= '0;
            o_alpha      <= '0;
            o_beta       <= '0;
            o_busy       <= 1'b0;
        end else if (abort_req && state != IDLE) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state            <= R_EVAL_START;
                        o_split_idx      <= '0;
                        o_start_evaluate <= 1'b1;
                        o_busy           <= 1'b1;
                    end
                end
                R_EVAL_START: state <= R_EVAL_WAIT;
                R_EVAL_WAIT: begin
                    if (i_done_evaluate) begin
                        work          <= i_evaluate_out;
                        eps           <= i_eps;
                        lane          <= '0;
                        o_x_mul32     <= lane_of(i_evaluate_out, 0);
                        o_y_mul32     <= lane_of(i_eps, 0);
                        o_start_mul32 <= 1'b1;
                        state         <= MUL_ISSUE;
                    end
                end
                MUL_ISSUE: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (i_done_mul32) begin
                        work <= work_upd;
                        if (lane == LAST_LANE) begin
                            o_in_1_add32  <= work_upd;
                            o_in_2_add32  <= i_a;
                            o_start_add32 <= 1'b1;
                            state         <= ADD_A_START;
                        end else begin
                            lane          <= lane + 1'b1;
                            o_x_mul32     <= lane_of(work, int'(lane) + 1);
                            o_y_mul32     <= lane_of(eps, int'(lane) + 1);
                            o_start_mul32 <= 1'b1;
                            state         <= MUL_ISSUE;
                        end
                    end
                end
                ADD_A_START: state <= ADD_A_WAIT;
                ADD_A_WAIT: begin
                    if (i_done_add32) begin
                        o_alpha          <= i_add_out_add32;
                        o_start_evaluate <= 1'b1;
                        state            <= S_EVAL_START;
                    end
                end
                S_EVAL_START: state <= S_EVAL_WAIT;
                S_EVAL_WAIT: begin
                    if (i_done_evaluate) begin
                        work          <= i_evaluate_out;
                        o_in_1_add32  <= i_evaluate_out;
                        o_in_2_add32  <= i_b;
                        o_start_add32 <= 1'b1;
                        state         <= ADD_B_START;
                    end
                end
                ADD_B_START: state <= ADD_B_WAIT;
                ADD_B_WAIT: begin
                    if (i_done_add32) begin
                        o_beta        <= i_add_out_add32;
                        o_split_valid <= 1'b1;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (o_split_idx == LAST_SPLIT) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        o_split_idx      <= o_split_idx + 1'b1;
                        o_start_evaluate <= 1'b1;
                        state            <= R_EVAL_START;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compute_plain_broadcast_split.sv
// Bench for compute_plain_broadcast_split (L3 set: T=3, D_SPLIT=2) with behavioural evaluate/mul/add stubs.
module tb_compute_plain_broadcast_split;
    localparam int         T      = 3;
    localparam int         TW     = 32 * T;
    localparam int         AW     = 9;
    localparam int         SW     = 2;
    localparam logic [7:0] Q_BYTE = 8'hAA;
    localparam logic [7:0] S_BYTE = 8'h55;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          i_rst, i_start, i_abort;
    logic [SW-1:0] o_split_idx;
    logic [TW-1:0] i_r, i_eps, i_a, i_b;
    logic [7:0]    i_q, i_s, o_q_s;
    logic [AW-1:0] o_q_addr, o_s_addr, i_q_s_addr;
    logic          o_q_rd, o_s_rd, i_q_s_rd;
    logic          o_start_evaluate, i_done_evaluate;
    logic [TW-1:0] o_r_eps, i_evaluate_out;
    logic          o_start_mul32, i_done_mul32;
    logic [31:0]   o_x_mul32, o_y_mul32, i_o_mul32;
    logic          o_start_add32, i_done_add32;
    logic [TW-1:0] o_in_1_add32, o_in_2_add32, i_add_out_add32;
    logic [TW-1:0] o_alpha, o_beta;
    logic          o_split_valid, o_busy, o_done;

    compute_plain_broadcast_split #(
        .PARAMETER_SET("L3"), .M(352), .T(3), .D_SPLIT(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
`ifdef PLAIN_BCAST_ABORT_EN
        .i_abort(i_abort),
`endif
        .o_split_idx(o_split_idx), .i_r(i_r), .i_eps(i_eps), .i_a(i_a), .i_b(i_b),
        .i_q(i_q), .i_s(i_s), .o_q_addr(o_q_addr), .o_s_addr(o_s_addr),
        .o_q_rd(o_q_rd), .o_s_rd(o_s_rd), .o_start_evaluate(o_start_evaluate), .o_q_s(o_q_s),
        .i_q_s_addr(i_q_s_addr), .i_q_s_rd(i_q_s_rd), .o_r_eps(o_r_eps),
        .i_evaluate_out(i_evaluate_out), .i_done_evaluate(i_done_evaluate),
        .o_start_mul32(o_start_mul32), .o_x_mul32(o_x_mul32), .o_y_mul32(o_y_mul32),
        .i_o_mul32(i_o_mul32), .i_done_mul32(i_done_mul32),
        .o_start_add32(o_start_add32), .o_in_1_add32(o_in_1_add32), .o_in_2_add32(o_in_2_add32),
        .i_add_out_add32(i_add_out_add32), .i_done_add32(i_done_add32),
        .o_alpha(o_alpha), .o_beta(o_beta), .o_split_valid(o_split_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct {
        logic [1:0][TW-1:0] r, q_ev, s_ev, eps, a, b, alpha, beta;
        int lat_e, lat_m, lat_a;   // 0 = random 1..20 per transaction
    } vec_t;

    vec_t vt [3];
    int   cur_v = 0;
    int   n_chk = 0, n_fail = 0;
    int   n_est = 0, n_mst = 0, n_ast = 0, overlap_err = 0;
    int   n_valid = 0, n_done = 0, exp_valid = 0, exp_done = 0;
    int   spur_req = 0, spur_ack = 0;

    // Parent mux: operands follow the split index.
    assign i_r   = vt[cur_v].r[o_split_idx[0]];
    assign i_eps = vt[cur_v].eps[o_split_idx[0]];
    assign i_a   = vt[cur_v].a[o_split_idx[0]];
    assign i_b   = vt[cur_v].b[o_split_idx[0]];

    function automatic int pick_lat(input int l);
        return (l == 0) ? int'($urandom_range(20, 1)) : l;
    endfunction

    // Carry-less product of small operands (all test operands fit in 16 bits, so no reduction).
    function automatic logic [31:0] clmul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) if (y[i]) acc ^= x << i;
        return acc;
    endfunction

    bit e_busy = 0, m_busy = 0, a_busy = 0;
    int e_left = 0, m_left = 0, a_left = 0;
    logic [TW-1:0] e_res, a_res;
    logic [31:0]   m_res;

    always @(negedge i_clk) begin
        i_done_evaluate = 1'b0;
        i_done_mul32    = 1'b0;
        i_done_add32    = 1'b0;
        if (o_split_valid) n_valid++;
        if (o_done) n_done++;
        if (e_busy) begin
            if (e_left <= 1) begin i_done_evaluate = 1'b1; i_evaluate_out = e_res; e_busy = 0; end
            else e_left--;
        end
        if (m_busy) begin
            if (m_left <= 1) begin i_done_mul32 = 1'b1; i_o_mul32 = m_res; m_busy = 0; end
            else m_left--;
        end
        if (a_busy) begin
            if (a_left <= 1) begin i_done_add32 = 1'b1; i_add_out_add32 = a_res; a_busy = 0; end
            else a_left--;
        end
        if (spur_req != spur_ack) begin
            i_done_add32    = 1'b1;
            i_add_out_add32 = '1;
            spur_ack        = spur_req;
        end
        if (o_start_evaluate) begin
            if (e_busy) overlap_err++;
            e_busy = 1; e_left = pick_lat(vt[cur_v].lat_e); n_est++;
            e_res  = (o_q_s == Q_BYTE) ? vt[cur_v].q_ev[o_split_idx[0]] : vt[cur_v].s_ev[o_split_idx[0]];
        end
        if (o_start_mul32) begin
            if (m_busy) overlap_err++;
            m_busy = 1; m_left = pick_lat(vt[cur_v].lat_m); n_mst++;
            m_res  = clmul(o_x_mul32, o_y_mul32);
        end
        if (o_start_add32) begin
            if (a_busy) overlap_err++;
            a_busy = 1; a_left = pick_lat(vt[cur_v].lat_a); n_ast++;
            a_res  = o_in_1_add32 ^ o_in_2_add32;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_split(input int v, input int s, input logic [TW-1:0] q, e, a, al,
                             input logic [TW-1:0] sv, b, be);
        vt[v].r[s]    = {32'(v), 32'(s), 32'hC0DE};
        vt[v].q_ev[s] = q;  vt[v].eps[s] = e;  vt[v].a[s] = a;  vt[v].alpha[s] = al;
        vt[v].s_ev[s] = sv; vt[v].b[s]   = b;  vt[v].beta[s] = be;
    endtask

    task automatic run_vec(input int v, input bit spur);
        int cyc, eb, mb, ab;
        cur_v = v;
        eb = n_est; mb = n_mst; ab = n_ast;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        chk("start_evaluate", o_start_evaluate, 1);
        chk("busy_after_start", o_busy, 1);
        chk("r_eps", o_r_eps, vt[v].r[0]);
        chk("q_s_is_q", o_q_s, Q_BYTE);
        if (spur) begin
            @(negedge i_clk); spur_req++; i_start = 1'b1;
            @(negedge i_clk); i_start = 1'b0;
            @(negedge i_clk);
            @(negedge i_clk);
            chk("spur_no_mul", o_start_mul32, 0);
            chk("spur_no_add", o_start_add32, 0);
            chk("spur_busy", o_busy, 1);
        end
        for (int s = 0; s < 2; s++) begin
            cyc = 0;
            while (!o_split_valid && cyc < 2000) begin @(negedge i_clk); cyc++; end
            chk("split_valid_seen", o_split_valid, 1);
            chk("split_idx", o_split_idx, s);
            chk("alpha", o_alpha, vt[v].alpha[s]);
            chk("beta", o_beta, vt[v].beta[s]);
            @(negedge i_clk);
            chk("done_after_split", o_done, (s == 1));
            if (s == 0) chk("next_split_eval", o_start_evaluate, 1);
        end
        @(negedge i_clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk("eval_starts", n_est - eb, 4);
        chk("mul_starts", n_mst - mb, 2 * T);
        chk("add_starts", n_ast - ab, 4);
        exp_valid += 2;
        exp_done  += 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, nv, nd;
        i_rst = 1'b1; i_start = 1'b1; i_abort = 1'b0;
        i_q = Q_BYTE; i_s = S_BYTE; i_q_s_addr = 9'h15A; i_q_s_rd = 1'b1;

        set_split(0, 0, {32'h1, 32'h1, 32'h1}, {32'h2, 32'h3, 32'h4}, {32'h10, 32'h20, 32'h30},
                  {32'h12, 32'h23, 32'h34}, {32'h5, 32'h6, 32'h7}, {32'h1, 32'h1, 32'h1}, {32'h4, 32'h7, 32'h6});
        set_split(0, 1, {32'h3, 32'h5, 32'h7}, {32'h3, 32'h3, 32'h2}, {32'h100, 32'h200, 32'h300},
                  {32'h105, 32'h20F, 32'h30E}, {32'hA, 32'hB, 32'hC}, {32'hF0, 32'h0F, 32'hFF}, {32'hFA, 32'h04, 32'hF3});
        set_split(1, 0, {32'h10, 32'h2, 32'hFF}, {32'h10, 32'h80, 32'h1}, {32'h0, 32'h1, 32'hFF},
                  {32'h100, 32'h101, 32'h0}, {32'h1234, 32'h0, 32'hFFFF0000},
                  {32'h4321, 32'hDEAD, 32'h0000FFFF}, {32'h5115, 32'hDEAD, 32'hFFFFFFFF});
        set_split(1, 1, {32'h3, 32'h6, 32'h9}, {32'h6, 32'h6, 32'h6}, {32'h1, 32'h1, 32'h1},
                  {32'hB, 32'h15, 32'h37}, {32'h11, 32'h22, 32'h33}, {32'h10, 32'h20, 32'h30}, {32'h1, 32'h2, 32'h3});
        vt[0].lat_e = 1; vt[0].lat_m = 1; vt[0].lat_a = 1;
        vt[1].lat_e = 5; vt[1].lat_m = 3; vt[1].lat_a = 7;
        vt[2] = vt[0];
        vt[2].lat_e = 0; vt[2].lat_m = 0; vt[2].lat_a = 0;

        // Reset asserted together with start: reset wins.
        repeat (3) @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_valid", o_split_valid, 0);
        chk("rst_start_eval", o_start_evaluate, 0);
        chk("rst_start_mul", o_start_mul32, 0);
        chk("rst_start_add", o_start_add32, 0);
        chk("rst_alpha", o_alpha, 0);
        chk("rst_beta", o_beta, 0);
        chk("rst_x_mul", o_x_mul32, 0);
        chk("rst_in_1", o_in_1_add32, 0);
        chk("rst_split_idx", o_split_idx, 0);
        chk("rst_q_s", o_q_s, S_BYTE);
        chk("q_addr", o_q_addr, 9'h15A);
        chk("s_addr", o_s_addr, 9'h15A);
        chk("q_rd", o_q_rd, 1);
        chk("s_rd", o_s_rd, 1);
        i_rst = 1'b0; i_start = 1'b0; i_q_s_rd = 1'b0;
        #1;
        chk("q_rd_low", o_q_rd, 0);

        for (int v = 0; v < 3; v++) run_vec(v, v == 1);

        // Reset in MUL_WAIT of split 0.
        cur_v = 1; nv = n_valid; nd = n_done;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        cyc = 0;
        while (!o_start_mul32 && cyc < 500) begin @(negedge i_clk); cyc++; end
        chk("mul_issue_seen", o_start_mul32, 1);
        @(negedge i_clk); i_rst = 1'b1;
        @(negedge i_clk); i_rst = 1'b0;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_alpha", o_alpha, 0);
        chk("midrst_beta", o_beta, 0);
        chk("midrst_x_mul", o_x_mul32, 0);
        chk("midrst_start_mul", o_start_mul32, 0);
        repeat (30) @(negedge i_clk);
        chk("midrst_no_valid", n_valid - nv, 0);
        chk("midrst_no_done", n_done - nd, 0);
        chk("midrst_still_idle", o_busy, 0);
        run_vec(0, 0);

`ifdef PLAIN_BCAST_ABORT_EN
        cur_v = 1; nv = n_valid; nd = n_done;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        cyc = 0;
        while (!(o_start_evaluate && o_q_s == S_BYTE) && cyc < 1000) begin @(negedge i_clk); cyc++; end
        chk("s_eval_seen", o_start_evaluate, 1);
        @(negedge i_clk); i_abort = 1'b1;
        @(negedge i_clk); i_abort = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_start_eval", o_start_evaluate, 0);
        chk("abort_alpha_held", o_alpha, vt[1].alpha[0]);
        repeat (30) @(negedge i_clk);
        chk("abort_no_valid", n_valid - nv, 0);
        chk("abort_no_done", n_done - nd, 0);
        chk("abort_still_idle", o_busy, 0);
`endif

        repeat (5) @(negedge i_clk);
        chk("total_valid", n_valid, exp_valid);
        chk("total_done", n_done, exp_done);
        chk("no_overlap", overlap_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
